// File: rtl/univ_shift_reg.sv
// Universal shift register: load/shift/rotate/clear per edge, plus a multi-cycle shift of amt steps.
// Optional XOR parity output port par when UNIV_SHIFT_REG_PARITY_EN is defined.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int              AW        = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic             par
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [0:0]       state_q, state_d;
  logic [2:0]       mode_lat_q, mode_lat_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (m)
      M_LOAD:  r = din;
      M_SHL:   r = {cur[WIDTH-2:0], sr};
      M_SHR:   r = {sl, cur[WIDTH-1:1]};
      M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
      M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLR:   r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    mode_lat_d = mode_lat_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    busy_d     = busy_q;
    // done is a pulse: it drops on every edge it is not explicitly raised
    done_d     = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (!start) begin
            q_d = apply_op(mode, q_q, d, sin_l, sin_r);
          end else if (mode == M_HOLD || mode == M_LOAD || mode == M_CLR) begin
            q_d    = apply_op(mode, q_q, d, sin_l, sin_r);
            done_d = 1'b1;
          end else if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            mode_lat_d = mode;
            cnt_d      = amt;
            busy_d     = 1'b1;
            state_d    = ST_BUSY;
          end
        end
        ST_BUSY: begin
          q_d   = apply_op(mode_lat_q, q_q, d, sin_l, sin_r);
          cnt_d = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_lat_q <= M_HOLD;
      cnt_q      <= '0;
      q_q        <= RESET_VAL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_lat_q <= mode_lat_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef UNIV_SHIFT_REG_PARITY_EN
  assign par = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): expected q/busy/done are queued before each edge
// and popped/compared one time unit after it.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int AW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             reset, en, sin_r, sin_l, start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] q;
  logic             sout_l, sout_r, busy, done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic             par;
`endif

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .amt(amt),
    .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
`ifdef UNIV_SHIFT_REG_PARITY_EN
    , .par(par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // Queue the expected result of the coming edge, clock it, then compare.
  task automatic tick(input string tag, input logic [WIDTH-1:0] eq, input logic eb, input logic ed);
    exp_t e;
    exp_t x;
    e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk({x.tag, ".q"}, 64'(q), 64'(x.q));
    chk({x.tag, ".busy"}, 64'(busy), 64'(x.busy));
    chk({x.tag, ".done"}, 64'(done), 64'(x.done));
    chk({x.tag, ".sout"}, 64'({sout_l, sout_r}), 64'({x.q[WIDTH-1], x.q[0]}));
`ifdef UNIV_SHIFT_REG_PARITY_EN
    chk({x.tag, ".par"}, 64'(par), 64'(^x.q));
`endif
    $display("step %-12s q=%h busy=%b done=%b", x.tag, q, busy, done);
  endtask

  task automatic drive(input logic [2:0] m, input logic [WIDTH-1:0] dv, input logic st, input logic [AW-1:0] a);
    mode = m; d = dv; start = st; amt = a;
  endtask

  initial begin
    logic [2:0] ops [5];
    logic [7:0] res [5];
    ops = '{3'b100, 3'b101, 3'b110, 3'b011, 3'b010};
    res = '{8'h03, 8'hC0, 8'hC0, 8'h40, 8'h03};

    reset = 1'b1; en = 1'b1; sin_r = 1'b0; sin_l = 1'b0;
    drive(3'b001, 8'hFF, 1'b0, '0);
    tick("rst0", 8'h00, 0, 0);
    tick("rst1", 8'h00, 0, 0);
    reset = 1'b0;

    drive(3'b001, 8'hA5, 0, '0); tick("loadA5", 8'hA5, 0, 0);
    en = 1'b0; drive(3'b010, 8'h00, 0, '0);
    for (int i = 0; i < 3; i++) tick("en0hold", 8'hA5, 0, 0);
    en = 1'b1;

    sin_r = 1'b1; sin_l = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(3'b001, 8'h81, 0, '0); tick("load81", 8'h81, 0, 0);
      drive(ops[i], 8'h00, 0, '0); tick($sformatf("op%0d", ops[i]), res[i], 0, 0);
    end
    sin_r = 1'b0;

    // multi-cycle SHL by 3; mode/d changes while busy must be ignored
    drive(3'b001, 8'h01, 0, '0); tick("load01", 8'h01, 0, 0);
    drive(3'b010, 8'h00, 1, 4'd3); tick("mstart", 8'h01, 1, 0);
    drive(3'b111, 8'hFF, 0, '0);
    tick("mshift1", 8'h02, 1, 0);
    tick("mshift2", 8'h04, 1, 0);
    tick("mdone", 8'h08, 0, 1);
    drive(3'b000, 8'h00, 0, '0); tick("mafter", 8'h08, 0, 0);

    // amt=0 and single-step op with start
    drive(3'b001, 8'h01, 0, '0); tick("load01b", 8'h01, 0, 0);
    drive(3'b010, 8'h00, 1, 4'd0); tick("amt0", 8'h01, 0, 1);
    drive(3'b001, 8'h3C, 1, 4'd5); tick("stload", 8'h3C, 0, 1);
    drive(3'b000, 8'h00, 0, '0); tick("stidle", 8'h3C, 0, 0);

    // stall one cycle, start pulsed while busy and on the completion edge
    drive(3'b001, 8'h01, 0, '0); tick("load01c", 8'h01, 0, 0);
    drive(3'b010, 8'h00, 1, 4'd3); tick("sstart", 8'h01, 1, 0);
    drive(3'b000, 8'h00, 0, '0); tick("sshift1", 8'h02, 1, 0);
    en = 1'b0; tick("sstall", 8'h02, 1, 0);
    en = 1'b1; drive(3'b011, 8'h00, 1, 4'd5); tick("sbusyst", 8'h04, 1, 0);
    drive(3'b011, 8'h00, 1, 4'd2); tick("sdone", 8'h08, 0, 1);
    drive(3'b000, 8'h00, 0, '0); tick("signored", 8'h08, 0, 0);

    // sin_r is sampled live during a multi-cycle shift
    drive(3'b001, 8'h01, 0, '0); tick("load01d", 8'h01, 0, 0);
    drive(3'b010, 8'h00, 1, 4'd2); tick("lstart", 8'h01, 1, 0);
    drive(3'b000, 8'h00, 0, '0); sin_r = 1'b1; tick("lshift1", 8'h03, 1, 0);
    sin_r = 1'b0; tick("ldone", 8'h06, 0, 1);

    // reset aborts a busy operation, and wins over start
    drive(3'b001, 8'h01, 0, '0); tick("load01e", 8'h01, 0, 0);
    drive(3'b010, 8'h00, 1, 4'd3); tick("rstart", 8'h01, 1, 0);
    drive(3'b000, 8'h00, 0, '0); tick("rshift1", 8'h02, 1, 0);
    reset = 1'b1; tick("rabort", 8'h00, 0, 0);
    reset = 1'b0; tick("rnodone1", 8'h00, 0, 0);
    tick("rnodone2", 8'h00, 0, 0);
    reset = 1'b1; drive(3'b010, 8'h00, 1, 4'd3); tick("rprio", 8'h00, 0, 0);
    reset = 1'b0; drive(3'b000, 8'h00, 0, '0); tick("rprio2", 8'h00, 0, 0);

    // parity endpoints (par itself is compared inside tick when present)
    drive(3'b001, 8'hA5, 0, '0); tick("parA5", 8'hA5, 0, 0);
    drive(3'b001, 8'hA4, 0, '0); tick("parA4", 8'hA4, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, 8, register width in bits; legal range 2..64.
REQ-002 Parameter RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
REQ-003 Local AW = $clog2(WIDTH)+1, the width of amt.
REQ-004 clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 en  in  1  enable; when 0, all state holds, including a multi-cycle op in progress.
REQ-007 mode  in  3  op select: 000 hold, 001 load d, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 clear.
REQ-008 d  in  WIDTH  parallel load data.
REQ-009 sin_r  in  1  serial input shifted into bit 0 on SHL.
REQ-010 sin_l  in  1  serial input shifted into bit WIDTH-1 on SHR.
REQ-011 start  in  1  requests a multi-cycle shift of amt steps.
REQ-012 amt  in  AW  shift count for a start request; 0..2^AW-1; not clamped.
REQ-013 q  out  WIDTH  register contents (registered).
REQ-014 sout_l  out  1  equals q[WIDTH-1] (combinational).
REQ-015 sout_r  out  1  equals q[0] (combinational).
REQ-016 busy  out  1  high while a multi-cycle shift is in progress (registered).
REQ-017 done  out  1  one-cycle completion pulse (registered).

Function
REQ-018 FSM states: IDLE and BUSY; the IDLE->BUSY decision is taken on the same edge that samples start.
REQ-019 IDLE, en=1, start=0: apply mode to q once per edge; done stays 0.
REQ-020 Op results: SHL={q[W-2:0],sin_r}; SHR={sin_l,q[W-1:1]}; ROL={q[W-2:0],q[W-1]}; ROR={q[0],q[W-1:1]}; ASR={q[W-1],q[W-1:1]}; clear=0; load=d; hold=q.
REQ-021 IDLE, en=1, start=1, mode in {000,001,111}: execute the op once at edge k; done=1 in the cycle after edge k; busy stays 0.
REQ-022 IDLE, en=1, start=1, shift mode, amt=0: q unchanged; done=1 after edge k; busy stays 0.
REQ-023 IDLE, en=1, start=1, shift mode, amt=N>0: at edge k latch mode and N into internal registers; busy=1; q unchanged.
REQ-024 BUSY: one latched shift per enabled edge (k+1..k+N); sin_l and sin_r are sampled live at each edge.
REQ-025 On the Nth shift edge: busy->0, done->1; q holds the final value while done=1.
REQ-026 BUSY ignores the mode, start, amt and d inputs.
REQ-027 BUSY with en=0 freezes q, the step counter and busy; completion is delayed by one cycle for each stalled cycle.
REQ-028 done is high for exactly one cycle per completed request.
REQ-029 A start that arrives on the completion edge is ignored; the next start is accepted only on an edge where busy=0.

Reset
REQ-030 reset=1 at an edge: q=RESET_VAL, busy=0, done=0, state=IDLE, step counter=0.
REQ-031 Reset takes priority over en and start.
REQ-032 Reset during BUSY aborts the operation; no done pulse follows.

Configuration
REQ-033 Macro UNIV_SHIFT_REG_PARITY_EN defined: output port par (1 bit) is present and equals XOR-reduce of q (combinational); reset therefore gives par = ^RESET_VAL.
REQ-034 Macro UNIV_SHIFT_REG_PARITY_EN undefined: port par and its logic are absent; all other behaviour is identical.

Verification (WIDTH=8, RESET_VAL=0)
REQ-035 reset=1 for 2 edges with en=1, mode=001, d=FF -> q=00, busy=0, done=0.
REQ-036 Load A5 (mode=001, en=1) -> q=A5; then en=0 with mode=010 for 3 edges -> q stays A5.
REQ-037 From q=81, one edge each: ROL->03, ROR->C0, ASR->C0, SHR with sin_l=0 ->40, SHL with sin_r=1 ->03.
REQ-038 From q=01: start=1, mode=010, amt=3, sin_r=0 -> busy=1 for 3 cycles, q=02,04,08, then done=1 for 1 cycle with q=08 and busy=0; amt=0 -> done next cycle, q=01.
REQ-039 Same run with en=0 for 1 cycle after the first shift -> q holds 02, done arrives 1 cycle later, and a start pulsed while busy is ignored.
REQ-040 Same run with reset=1 after the first shift -> q=00, busy=0 and done stays 0; with UNIV_SHIFT_REG_PARITY_EN defined and q=A5, par=0, and with q=A4, par=1.
